// File: rtl/alu_seq_n.sv
// rtl/alu_seq_n.sv - registered WIDTH-bit ALU with handshake, carry chaining, multi-cycle shifts and multiply
module alu_seq_n #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             c,
    output logic             n,
    output logic             z,
    output logic             v
);
    localparam int CNTW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);
    localparam logic [CNTW-1:0]  W_CNT = CNTW'(WIDTH);
    localparam logic [CNTW-1:0]  CNT_ONE = CNTW'(1);

    localparam logic [3:0] OP_ADD = 4'b0110;
    localparam logic [3:0] OP_SUB = 4'b0111;
    localparam logic [3:0] OP_ADC = 4'b1000;
    localparam logic [3:0] OP_SBC = 4'b1001;
    localparam logic [3:0] OP_SHL = 4'b1010;
    localparam logic [3:0] OP_SHR = 4'b1011;
    localparam logic [3:0] OP_ASR = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b1101;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state;
    logic [3:0]        op_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  sh;
    logic [WIDTH-1:0]  acc;
    logic [CNTW-1:0]   cnt;
    logic              cin_q;

    logic [WIDTH-1:0]  add_b;
    logic              add_ci;
    logic [WIDTH:0]    add_sum;
    logic              add_v;
    logic [WIDTH-1:0]  sc_res;
    logic              sc_c;
    logic              sc_v;
    logic [CNTW-1:0]   k_in;
    logic              go_busy;
    logic [WIDTH:0]    mul_sum;
    logic [WIDTH-1:0]  step_res;
    logic [WIDTH-1:0]  step_hi;
    logic              step_c;
    logic [WIDTH-1:0]  fin_res;
    logic              fin_c;
    logic              fin_v;
    logic              load_done;

    always_comb begin
        add_b  = (op == OP_SUB || op == OP_SBC) ? ~b : b;
        add_ci = 1'b0;
        if (op == OP_SUB)
            add_ci = 1'b1;
        else if (op == OP_ADC || op == OP_SBC)
            add_ci = cin_q;
        add_sum = {1'b0, a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_ci};
        // carry into the MSB recovered from the sum bit, XORed with carry out
        add_v = a[WIDTH-1] ^ add_b[WIDTH-1] ^ add_sum[WIDTH-1] ^ add_sum[WIDTH];

        sc_res = '0;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        case (op)
            4'b0000: sc_res = ~a;
            4'b0001: sc_res = ~b;
            4'b0010: sc_res = a & b;
            4'b0011: sc_res = a | b;
            4'b0100: sc_res = a ^ b;
            4'b0101: sc_res = ~(a ^ b);
            OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
                sc_res = add_sum[WIDTH-1:0];
                sc_c   = add_sum[WIDTH];
                sc_v   = add_v;
            end
            OP_SHL, OP_SHR, OP_ASR: sc_res = a;
            default: sc_res = '0;
        endcase

        k_in    = (b >= W_VAL) ? W_CNT : b[CNTW-1:0];
        go_busy = ((op == OP_SHL || op == OP_SHR || op == OP_ASR) && k_in != '0) || op == OP_MUL;

        // multiply keeps the multiplier in sh; product low bits shift in from the top
        mul_sum  = {1'b0, acc} + (sh[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
        step_res = sh;
        step_hi  = acc;
        step_c   = 1'b0;
        case (op_q)
            OP_SHL: begin
                step_res = {sh[WIDTH-2:0], 1'b0};
                step_c   = sh[WIDTH-1];
            end
            OP_SHR: begin
                step_res = {1'b0, sh[WIDTH-1:1]};
                step_c   = sh[0];
            end
            OP_ASR: begin
                step_res = {sh[WIDTH-1], sh[WIDTH-1:1]};
                step_c   = sh[0];
            end
            OP_MUL: begin
                step_res = {mul_sum[0], sh[WIDTH-1:1]};
                step_hi  = mul_sum[WIDTH:1];
            end
            default: step_res = sh;
        endcase

        if (state == BUSY) begin
            fin_res = step_res;
            fin_c   = step_c;
            fin_v   = (op_q == OP_MUL) && (|step_hi);
        end else begin
            fin_res = sc_res;
            fin_c   = sc_c;
            fin_v   = sc_v;
        end
        load_done = (state == IDLE && in_valid && !go_busy) || (state == BUSY && cnt == CNT_ONE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            c         <= 1'b0;
            n         <= 1'b0;
            z         <= 1'b0;
            v         <= 1'b0;
            cin_q     <= 1'b0;
            op_q      <= '0;
            a_q       <= '0;
            sh        <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q     <= op;
                        a_q      <= a;
                        in_ready <= 1'b0;
                        if (go_busy) begin
                            state <= BUSY;
                            cnt   <= (op == OP_MUL) ? W_CNT : k_in;
                            sh    <= (op == OP_MUL) ? b : a;
                            acc   <= '0;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                BUSY: begin
                    sh  <= step_res;
                    acc <= step_hi;
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE)
                        state <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            if (load_done) begin
                out_valid <= 1'b1;
                result    <= fin_res;
                c         <= fin_c;
                n         <= fin_res[WIDTH-1];
                z         <= ~|fin_res;
                v         <= fin_v;
                cin_q     <= fin_c;
            end
        end
    end
endmodule

// File: tb/tb_alu_seq_n.sv
// tb/tb_alu_seq_n.sv - randomized and directed bench for alu_seq_n at WIDTH 4 and 8
module tb_alu_seq_n;
    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] a_i, b_i;
    logic [3:0] op_i;
    logic       iv4, iv8, or4, or8;
    logic       ir4, ov4, c4, n4, z4, v4;
    logic       ir8, ov8, c8, n8, z8, v8;
    logic [3:0] res4;
    logic [7:0] res8;
    logic       sel;
    logic       cin4, cin8;
    int         n_checks = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    alu_seq_n #(.WIDTH(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv4), .in_ready(ir4),
        .a(a_i[3:0]), .b(b_i[3:0]), .op(op_i), .out_valid(ov4), .out_ready(or4),
        .result(res4), .c(c4), .n(n4), .z(z4), .v(v4)
    );

    alu_seq_n #(.WIDTH(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv8), .in_ready(ir8),
        .a(a_i), .b(b_i), .op(op_i), .out_valid(ov8), .out_ready(or8),
        .result(res8), .c(c8), .n(n8), .z(z8), .v(v8)
    );

    wire        ir_s = sel ? ir8 : ir4;
    wire        ov_s = sel ? ov8 : ov4;
    wire [35:0] got_s = sel ? {24'd0, res8, c8, n8, z8, v8} : {28'd0, res4, c4, n4, z4, v4};

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic longint sx(input longint unsigned x, input int w);
        if (x[w-1]) return longint'(x) - (longint'(1) << w);
        return longint'(x);
    endfunction

    // Reference: plain integer arithmetic on the operands, no per-cycle modelling
    function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                  input logic [3:0] op, input logic cin,
                                  output logic [31:0] r, output logic c, output logic v, output int lat);
        longint unsigned mask, ua, ub, nb, s;
        longint ts;
        int k;
        logic ci;
        mask = (64'd1 << w) - 64'd1;
        ua = {32'd0, a} & mask;
        ub = {32'd0, b} & mask;
        k = (ub > longint'(w)) ? w : int'(ub);
        s = 0; c = 1'b0; v = 1'b0; lat = 1;
        case (op)
            4'd0: s = ~ua;
            4'd1: s = ~ub;
            4'd2: s = ua & ub;
            4'd3: s = ua | ub;
            4'd4: s = ua ^ ub;
            4'd5: s = ~(ua ^ ub);
            4'd6, 4'd7, 4'd8, 4'd9: begin
                nb = (op == 4'd7 || op == 4'd9) ? (~ub & mask) : ub;
                ci = (op == 4'd7) ? 1'b1 : ((op >= 4'd8) ? cin : 1'b0);
                s  = ua + nb + {63'd0, ci};
                c  = s[w];
                ts = sx(ua, w) + sx(nb, w) + longint'({63'd0, ci});
                v  = (ts > (longint'(1) << (w - 1)) - 1) || (ts < -(longint'(1) << (w - 1)));
            end
            4'd10: begin
                s = ua << k;
                if (k > 0) c = ua[w-k];
                lat = 1 + k;
            end
            4'd11, 4'd12: begin
                ts = (op == 4'd12) ? (sx(ua, w) >>> k) : longint'(ua >> k);
                s  = longint'(ts);
                if (k > 0) c = ua[k-1];
                lat = 1 + k;
            end
            4'd13: begin
                s   = ua * ub;
                v   = (s >> w) != 0;
                lat = 1 + w;
            end
            default: s = 0;
        endcase
        r = 32'(s & mask);
    endfunction

    task automatic expect_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                             output logic [35:0] e, output int elat);
        int w;
        logic [31:0] r;
        logic c, v;
        w = sel ? 8 : 4;
        model(w, a, b, op, sel ? cin8 : cin4, r, c, v, elat);
        e = {r, c, r[w-1], (r == 32'd0), v};
        if (sel) cin8 = c; else cin4 = c;
    endtask

    task automatic exec(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                        output logic [35:0] got, output int lat);
        int g;
        g = 0;
        @(negedge clk);
        while (!ir_s && g < 100) begin @(negedge clk); g++; end
        a_i = a[7:0]; b_i = b[7:0]; op_i = op;
        if (sel) iv8 = 1'b1; else iv4 = 1'b1;
        @(posedge clk); #1;
        iv4 = 1'b0; iv8 = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!ov_s && lat < 100) begin @(negedge clk); lat++; end
        got = got_s;
        if (sel) or8 = 1'b1; else or4 = 1'b1;
        @(posedge clk); #1;
        or4 = 1'b0; or8 = 1'b0;
    endtask

    task automatic test_reset();
        logic [40:0] exp_r;
        reset_n = 1'b0; iv4 = 0; iv8 = 0; or4 = 0; or8 = 0;
        a_i = '0; b_i = '0; op_i = '0; sel = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        cin4 = 1'b0; cin8 = 1'b0;
        @(negedge clk);
        exp_r = {1'b1, 1'b0, 35'd0, 4'd0};
        n_checks++;
        if ({ir4, ov4, 31'd0, res4, c4, n4, z4, v4} !== exp_r) begin
            n_fail++;
            $display("FAIL reset_w4: got ir=%b ov=%b res=%h cnzv=%b%b%b%b, expected ir=1 ov=0 res=0 cnzv=0000",
                     ir4, ov4, res4, c4, n4, z4, v4);
        end
        n_checks++;
        if ({ir8, ov8, res8, c8, n8, z8, v8} !== {2'b10, 8'd0, 4'd0}) begin
            n_fail++;
            $display("FAIL reset_w8: got ir=%b ov=%b res=%h cnzv=%b%b%b%b, expected ir=1 ov=0 res=0 cnzv=0000",
                     ir8, ov8, res8, c8, n8, z8, v8);
        end
    endtask

    task automatic test_page0_sweep();
        logic [35:0] got, e;
        int lat, elat;
        sel = 1'b0;
        exec(32'h7, 32'h1, 4'b0110, got, lat);
        expect_op(32'h7, 32'h1, 4'b0110, e, elat);
        e = {32'h8, 1'b0, 1'b1, 1'b0, 1'b1};
        n_checks++;
        if (got !== e || lat !== 1) begin
            n_fail++;
            $display("FAIL spot_add_w4: got %h lat %0d, expected %h lat 1", got, lat, e);
        end
        for (int o = 0; o < 8; o++)
            for (int x = 0; x < 16; x++)
                for (int y = 0; y < 16; y++) begin
                    exec(x, y, 4'(o), got, lat);
                    expect_op(x, y, 4'(o), e, elat);
                    n_checks++;
                    if (got !== e || lat !== elat) begin
                        n_fail++;
                        $display("FAIL page0 op=%0d a=%h b=%h: got %h lat %0d, expected %h lat %0d",
                                 o, x, y, got, lat, e, elat);
                    end
                end
    endtask

    task automatic test_carry_chain();
        logic [35:0] got, e;
        int lat, elat;
        sel = 1'b0;
        exec(32'hF, 32'h1, 4'b0110, got, lat);
        expect_op(32'hF, 32'h1, 4'b0110, e, elat);
        n_checks++;
        if (got !== {32'h0, 4'b1010}) begin
            n_fail++;
            $display("FAIL chain_low: got %h, expected %h", got, {32'h0, 4'b1010});
        end
        exec(32'h2, 32'h3, 4'b1000, got, lat);
        expect_op(32'h2, 32'h3, 4'b1000, e, elat);
        n_checks++;
        if (got !== {32'h6, 4'b0000} || lat !== 1) begin
            n_fail++;
            $display("FAIL chain_high: got %h lat %0d, expected %h lat 1", got, lat, {32'h6, 4'b0000});
        end
    endtask

    task automatic test_shift_mul_directed();
        logic [35:0] got, e;
        int lat, elat;
        logic [31:0] ta [5] = '{32'h81, 32'h81, 32'h81, 32'h0F, 32'h10};
        logic [31:0] tb [5] = '{32'd1, 32'd3, 32'd20, 32'h11, 32'h10};
        logic [3:0]  to [5] = '{4'b1010, 4'b1100, 4'b1011, 4'b1101, 4'b1101};
        logic [35:0] te [5] = '{{32'h02, 4'b1000}, {32'hF0, 4'b0100}, {32'h00, 4'b1010},
                                {32'hFF, 4'b0100}, {32'h00, 4'b0011}};
        int          tl [5] = '{2, 4, 9, 9, 9};
        sel = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exec(ta[i], tb[i], to[i], got, lat);
            expect_op(ta[i], tb[i], to[i], e, elat);
            n_checks++;
            if (got !== te[i] || lat !== tl[i]) begin
                n_fail++;
                $display("FAIL directed_w8_%0d: got %h lat %0d, expected %h lat %0d", i, got, lat, te[i], tl[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [35:0] got, e;
        int lat, elat;
        logic [31:0] ra, rb;
        logic [3:0] ro;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            for (int i = 0; i < 200; i++) begin
                ra = $urandom; rb = $urandom;
                ro = 4'($urandom_range(0, 15));
                if (ro >= 4'd10 && ro <= 4'd12 && $urandom_range(0, 1) == 1)
                    rb = $urandom_range(0, 10);
                exec(ra, rb, ro, got, lat);
                expect_op(ra, rb, ro, e, elat);
                n_checks++;
                if (got !== e || lat !== elat) begin
                    n_fail++;
                    $display("FAIL random w=%0d op=%0d a=%h b=%h: got %h lat %0d, expected %h lat %0d",
                             sel ? 8 : 4, ro, ra[7:0], rb[7:0], got, lat, e, elat);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [35:0] e;
        int elat, g;
        sel = 1'b1;
        @(negedge clk);
        a_i = 8'h5A; b_i = 8'h33; op_i = 4'b0110; iv8 = 1'b1;
        @(posedge clk); #1 iv8 = 1'b0;
        expect_op(32'h5A, 32'h33, 4'b0110, e, elat);
        g = 0;
        @(negedge clk);
        while (!ov8 && g < 50) begin @(negedge clk); g++; end
        n_checks++;
        if (got_s !== e || e !== {32'h8D, 4'b0101}) begin
            n_fail++;
            $display("FAIL bp_result: got %h, expected %h", got_s, e);
        end
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin a_i = 8'h01; b_i = 8'h01; op_i = 4'b0000; end
            iv8 = (i == 2);
            @(negedge clk);
            n_checks++;
            if ({ov8, ir8, got_s} !== {2'b10, e}) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: got ov=%b ir=%b %h, expected ov=1 ir=0 %h", i, ov8, ir8, got_s, e);
            end
        end
        iv8 = 1'b0;
        or8 = 1'b1;
        @(posedge clk); #1 or8 = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({ov8, ir8, got_s} !== {2'b01, e}) begin
            n_fail++;
            $display("FAIL bp_release: got ov=%b ir=%b %h, expected ov=0 ir=1 %h", ov8, ir8, got_s, e);
        end
    endtask

    task automatic test_reset_mid_mul();
        logic [35:0] got, e;
        int lat, elat, seen;
        sel = 1'b1;
        @(negedge clk);
        a_i = 8'h0F; b_i = 8'h11; op_i = 4'b1101; iv8 = 1'b1;
        @(posedge clk); #1 iv8 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1'b0;
        @(posedge clk); #1 reset_n = 1'b1;
        cin4 = 1'b0; cin8 = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({ov8, ir8, res8, c8, n8, z8, v8} !== {2'b01, 12'd0}) begin
            n_fail++;
            $display("FAIL mid_mul_reset: got ov=%b ir=%b res=%h cnzv=%b%b%b%b, expected ov=0 ir=1 res=0 cnzv=0000",
                     ov8, ir8, res8, c8, n8, z8, v8);
        end
        seen = 0;
        for (int i = 0; i < 12; i++) begin @(negedge clk); if (ov8) seen++; end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL mid_mul_discard: got %0d valid cycles, expected 0", seen);
        end
        exec(32'h1, 32'h1, 4'b1000, got, lat);
        expect_op(32'h1, 32'h1, 4'b1000, e, elat);
        n_checks++;
        if (got !== {32'h2, 4'b0000} || got !== e) begin
            n_fail++;
            $display("FAIL adc_after_reset: got %h, expected %h", got, {32'h2, 4'b0000});
        end
    endtask

    initial begin
        test_reset();
        test_page0_sweep();
        test_carry_chain();
        test_shift_mul_directed();
        test_random();
        test_backpressure();
        test_reset_mid_mul();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
